uart_echo_buffer: RTL and testbench

- Byte buffer between the UART receiver output (data byte plus one-cycle done pulse) and the UART transmitter input (enable plus data, done pulse on completion).
- Absorbs back-to-back received bytes in a FIFO.
- Launches one transmit at a time, waiting for the transmitter's done pulse before launching the next byte.
- Replaces the direct rx-to-tx wiring in the loopback top level, so bytes arriving while the transmitter is busy are not lost.

---
 rtl/uart_echo_buffer.sv | 131 +++++++++++++
 tb/tb_uart_echo_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buffer.sv
// Byte FIFO between UART rx and tx: absorbs received bytes and launches one transmit at a time.
// Optional tx-done watchdog enabled by defining UART_ECHO_TIMEOUT_EN.
module uart_echo_buffer #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_done_i,
  input  logic              tx_done_i,
  output logic              tx_en_o,
  output logic [7:0]        tx_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              tx_timeout_o
);

  typedef enum logic [0:0] {IDLE, WAIT_DONE} state_t;

  // Reject parameter sets the pointer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH != (32'(1) << ADDR_W) ||
      TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("uart_echo_buffer: illegal DEPTH/ADDR_W/TIMEOUT_CYCLES");
  end

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              pop, wr, drop;

`ifdef UART_ECHO_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer;
  logic             expire;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Launch from IDLE whenever a byte is queued; tx_done beats watchdog expiry.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
`ifdef UART_ECHO_TIMEOUT_EN
    expire     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty_o) begin
          pop        = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done_i) state_next = IDLE;
`ifdef UART_ECHO_TIMEOUT_EN
        else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign wr   = rx_done_i && (!full_o || pop);
  assign drop = rx_done_i && full_o && !pop;

  always_comb begin
    count_next = count_o;
    case ({wr, pop})
      2'b10:   count_next = count_o + (ADDR_W+1)'(1);
      2'b01:   count_next = count_o - (ADDR_W+1)'(1);
      default: count_next = count_o;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      overflow_o <= 1'b0;
      tx_en_o    <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      count_o <= count_next;
      empty_o <= (count_next == '0);
      full_o  <= (count_next == (ADDR_W+1)'(DEPTH));
      tx_en_o <= pop;
      if (wr)   wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        tx_data_o <= mem[rd_ptr];
      end
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef UART_ECHO_TIMEOUT_EN
  // Watchdog counts cycles spent in WAIT_DONE; restarts at each launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      tx_timeout_o <= 1'b0;
    end else begin
      if (pop)                     timer <= '0;
      else if (state == WAIT_DONE) timer <= timer + TMR_W'(1);
      if (expire) tx_timeout_o <= 1'b1;
    end
  end
`else
  assign tx_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed self-checking bench for uart_echo_buffer (timeout case runs when UART_ECHO_TIMEOUT_EN is defined).
module tb_uart_echo_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data_i;
  logic              rx_done_i;
  logic              tx_done_i;
  logic              tx_en_o;
  logic [7:0]        tx_data_o;
  logic [ADDR_W:0]   count_o;
  logic              empty_o;
  logic              full_o;
  logic              overflow_o;
  logic              tx_timeout_o;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  got [$];

  uart_echo_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .tx_done_i(tx_done_i), .tx_en_o(tx_en_o), .tx_data_o(tx_data_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o), .tx_timeout_o(tx_timeout_o)
  );

  always #5 clk = ~clk;

  // Record every launched byte, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && tx_en_o) got.push_back(tx_data_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    cyc();
    rx_done_i = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
  endtask

  // Release n queued bytes: done -> IDLE edge -> pop edge.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_done();
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int peak;
    rst = 1'b1; rx_data_i = 8'h00; rx_done_i = 1'b0; tx_done_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(count_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_tx_en", 32'(tx_en_o), 0);
    check("rst_tx_data", 32'(tx_data_o), 32'h00);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_timeout", 32'(tx_timeout_o), 0);

    // Single byte latency
    got.delete();
    send(8'hA5);
    check("t1_count_after_rx", 32'(count_o), 1);
    check("t1_no_early_en", 32'(tx_en_o), 0);
    cyc();
    check("t1_en", 32'(tx_en_o), 1);
    check("t1_data", 32'(tx_data_o), 32'hA5);
    check("t1_count_zero", 32'(count_o), 0);
    cyc();
    check("t1_en_drop", 32'(tx_en_o), 0);
    check("t1_data_hold", 32'(tx_data_o), 32'hA5);
    repeat (100) cyc();
    check("t1_launches", 32'(got.size()), 1);
    pulse_done();

    // Burst 01..05, done 50 cycles after each launch
    got.delete();
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i));
      if (int'(count_o) > peak) peak = int'(count_o);
    end
    check("t2_peak", 32'(peak), 4);
    for (int i = 0; i < 5; i++) begin
      repeat (50) cyc();
      pulse_done();
    end
    cyc();
    check("t2_launches", 32'(got.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check("t2_order", 32'(got[i]), 32'(i + 1));
    check("t2_ovf", 32'(overflow_o), 0);
    check("t2_empty", 32'(empty_o), 1);

    // Overflow: one byte in flight, then DEPTH+1 more
    got.delete();
    send(8'hEE);
    cyc();
    for (int i = 0; i <= DEPTH; i++) send(8'(8'h20 + i));
    check("t3_full", 32'(full_o), 1);
    check("t3_count", 32'(count_o), DEPTH);
    check("t3_ovf", 32'(overflow_o), 1);
    drain(DEPTH);
    pulse_done();
    cyc();
    check("t3_launches", 32'(got.size()), DEPTH + 1);
    if (got.size() > 0) check("t3_first", 32'(got[0]), 32'hEE);
    for (int i = 1; i <= DEPTH; i++)
      if (i < got.size()) check("t3_order", 32'(got[i]), 32'(8'h20 + i - 1));
    check("t3_empty", 32'(empty_o), 1);

    // Full FIFO, write coincident with pop
    do_reset();
    got.delete();
    send(8'hEE);
    cyc();
    for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i));
    check("t4_full_pre", 32'(full_o), 1);
    check("t4_ovf_pre", 32'(overflow_o), 0);
    pulse_done();
    send(8'h77);
    check("t4_count", 32'(count_o), DEPTH);
    check("t4_full", 32'(full_o), 1);
    check("t4_ovf", 32'(overflow_o), 0);
    check("t4_en", 32'(tx_en_o), 1);
    check("t4_data", 32'(tx_data_o), 32'h40);
    drain(DEPTH);
    pulse_done();
    cyc();
    check("t4_launches", 32'(got.size()), DEPTH + 2);
    if (got.size() == DEPTH + 2) check("t4_last", 32'(got[DEPTH + 1]), 32'h77);

    // Reset during WAIT_DONE with 3 queued
    send(8'h51);
    cyc();
    send(8'h52); send(8'h53); send(8'h54);
    check("t5_count_pre", 32'(count_o), 3);
    do_reset();
    check("t5_count", 32'(count_o), 0);
    check("t5_empty", 32'(empty_o), 1);
    check("t5_data", 32'(tx_data_o), 32'h00);
    check("t5_en", 32'(tx_en_o), 0);
    got.delete();
    repeat (3) cyc();
    pulse_done();
    repeat (10) cyc();
    check("t5_quiet", 32'(got.size()), 0);
    send(8'h66);
    cyc();
    check("t5_new_en", 32'(tx_en_o), 1);
    check("t5_new_data", 32'(tx_data_o), 32'h66);
    pulse_done();
    cyc();

`ifdef UART_ECHO_TIMEOUT_EN
    // Watchdog expiry after 20 WAIT_DONE cycles
    send(8'h81);
    cyc();
    check("to_launch", 32'(tx_data_o), 32'h81);
    send(8'h82);
    repeat (18) cyc();
    check("to_not_yet", 32'(tx_timeout_o), 0);
    cyc();
    check("to_flag", 32'(tx_timeout_o), 1);
    check("to_no_en", 32'(tx_en_o), 0);
    cyc();
    check("to_next_en", 32'(tx_en_o), 1);
    check("to_next_data", 32'(tx_data_o), 32'h82);
    pulse_done();
    cyc();
`else
    check("to_tied", 32'(tx_timeout_o), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
